// File: rtl/div_restore_32.sv
// div_restore_32: iterative restoring divider for the DIV instruction.
// One quotient bit per cycle. The quotient feeds LO and the remainder feeds
// HI via the ALU result mux. Completion is a one-cycle done pulse.
// Optional feature macro: SIGNED_DIV_EN (two's-complement division).
// When it is undefined, the divider is unsigned and no sign logic exists.
module div_restore_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic             dbzFlag_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             divByZero_q;

    logic [WIDTH:0]   shiftRem;
    logic [WIDTH:0]   trialDiff;
    logic [WIDTH-1:0] remNext_d;
    logic [WIDTH-1:0] quoNext_d;

    logic [WIDTH-1:0] dvdMag;
    logic [WIDTH-1:0] dvsMag;
    logic [WIDTH-1:0] quoFinal;
    logic [WIDTH-1:0] remFinal;

`ifdef SIGNED_DIV_EN
    logic qNeg_q;
    logic rNeg_q;

    // Operand magnitudes for the unsigned core; the most-negative value maps to itself, which is the correct unsigned magnitude.
    always_comb begin
        dvdMag = dividend[WIDTH-1] ? -dividend : dividend;
        dvsMag = divisor[WIDTH-1]  ? -divisor  : divisor;
    end

    // Apply the result signs in the final cycle; a zero divisor keeps its fixed results unsigned.
    always_comb begin
        quoFinal = quo_q;
        remFinal = rem_q;
        if (!dbzFlag_q) begin
            if (qNeg_q) quoFinal = -quo_q;
            if (rNeg_q) remFinal = -rem_q;
        end
    end
`else
    assign dvdMag   = dividend;
    assign dvsMag   = divisor;
    assign quoFinal = quo_q;
    assign remFinal = rem_q;
`endif

    // One restoring step. The partial remainder always stays below the divisor, so WIDTH bits
    // hold it between steps. Only the shifted value needs the extra bit, and the trial
    // subtract's top bit acts as the borrow.
    always_comb begin
        shiftRem  = {rem_q, quo_q[WIDTH-1]};
        trialDiff = shiftRem - {1'b0, div_q};
        if (trialDiff[WIDTH]) begin
            remNext_d = shiftRem[WIDTH-1:0];
            quoNext_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            remNext_d = trialDiff[WIDTH-1:0];
            quoNext_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Control FSM plus datapath registers; all outputs are registered.
    // In IDLE, start is not accepted while done is still high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            dbzFlag_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
`ifdef SIGNED_DIV_EN
            qNeg_q      <= 1'b0;
            rNeg_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !done_q) begin
                        busy_q <= 1'b1;
                        div_q  <= dvsMag;
`ifdef SIGNED_DIV_EN
                        qNeg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rNeg_q <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            rem_q     <= dividend;
                            quo_q     <= '1;
                            dbzFlag_q <= 1'b1;
                            count_q   <= '0;
                            state_q   <= FIN;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= dvdMag;
                            dbzFlag_q <= 1'b0;
                            count_q   <= CW'(WIDTH);
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q   <= remNext_d;
                    quo_q   <= quoNext_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    quotient_q  <= quoFinal;
                    remainder_q <= remFinal;
                    divByZero_q <= dbzFlag_q;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_div_restore_32.sv
// Testbench for div_restore_32: table-driven vectors plus handshake and reset sequences.
module tb_div_restore_32;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs [12];

    div_restore_32 #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Hard stop so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%h required=0x%h", name, actual, expected);
        end
    endtask

    // Start one operation. Count edges (the start edge included) until done is sampled,
    // and count the busy cycles seen. Returns at the negedge where done is high,
    // or after 100 edges.
    task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                 output int lat, output int busyCnt);
        @(negedge clock);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        lat      = 0;
        busyCnt  = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            start    = 1'b0;
            dividend = ~dvd;
            divisor  = ~dvs;
            if (busy) busyCnt++;
            if (done) break;
        end
    endtask

    initial begin
        int lat;
        int busyCnt;
        int cyc;
        logic sawDone;

`ifdef SIGNED_DIV_EN
        vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
        vecs[1]  = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 34};
        vecs[2]  = '{32'd5,        32'hFFFFFFFF, 32'hFFFFFFFB, 32'd0,        1'b0, 34};
        vecs[3]  = '{32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 2};
        vecs[4]  = '{32'd0,        32'd7,        32'd0,        32'd0,        1'b0, 34};
        vecs[5]  = '{32'd7,        32'd7,        32'd1,        32'd0,        1'b0, 34};
        vecs[6]  = '{32'd6,        32'd7,        32'd0,        32'd6,        1'b0, 34};
        vecs[7]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 34};
        vecs[8]  = '{32'hDEADBEEF, 32'h10,       32'hFDEADBEF, 32'hFFFFFFFF, 1'b0, 34};
        vecs[9]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
        vecs[10] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
        vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34};
`else
        vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
        vecs[1]  = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 34};
        vecs[2]  = '{32'd5,        32'hFFFFFFFF, 32'd0,        32'd5,        1'b0, 34};
        vecs[3]  = '{32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 2};
        vecs[4]  = '{32'd0,        32'd7,        32'd0,        32'd0,        1'b0, 34};
        vecs[5]  = '{32'd7,        32'd7,        32'd1,        32'd0,        1'b0, 34};
        vecs[6]  = '{32'd6,        32'd7,        32'd0,        32'd6,        1'b0, 34};
        vecs[7]  = '{32'h80000000, 32'd2,        32'h40000000, 32'd0,        1'b0, 34};
        vecs[8]  = '{32'hDEADBEEF, 32'h10,       32'h0DEADBEE, 32'h0000000F, 1'b0, 34};
        vecs[9]  = '{32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0, 34};
        vecs[10] = '{32'd7,        32'hFFFFFFFE, 32'd0,        32'd7,        1'b0, 34};
        vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34};
`endif

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset_busy",      W'(busy),        '0);
        checkOutput("reset_done",      W'(done),        '0);
        checkOutput("reset_quotient",  quotient,        '0);
        checkOutput("reset_remainder", remainder,       '0);
        checkOutput("reset_dbz",       W'(div_by_zero), '0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].dvd, vecs[i].dvs, lat, busyCnt);
            checkOutput($sformatf("v%0d_latency", i),   W'(lat),          W'(vecs[i].lat));
            checkOutput($sformatf("v%0d_busyCycles", i), W'(busyCnt),     W'(vecs[i].lat - 1));
            checkOutput($sformatf("v%0d_quotient", i),  quotient,         vecs[i].q);
            checkOutput($sformatf("v%0d_remainder", i), remainder,        vecs[i].r);
            checkOutput($sformatf("v%0d_dbz", i),       W'(div_by_zero),  W'(vecs[i].dbz));
            @(negedge clock);
            checkOutput($sformatf("v%0d_donePulse", i), W'(done),         '0);
        end

        // Handshake: starts during RUN and during the done cycle are ignored.
        @(negedge clock);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        cyc      = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            cyc++;
            if (done) break;
            start = (cyc == 10);
            if (cyc == 10) begin
                dividend = 32'd9;
                divisor  = 32'd3;
            end
        end
        checkOutput("hs_latency",   W'(cyc),  32'd34);
        checkOutput("hs_quotient",  quotient, 32'd10);
        checkOutput("hs_remainder", remainder, 32'd0);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("hs_doneStartIgnored", W'(busy), '0);
        checkOutput("hs_quotientHeld",     quotient, 32'd10);
        applyStimulus(32'd9, 32'd3, lat, busyCnt);
        checkOutput("hs_nextLatency",   W'(lat),  32'd34);
        checkOutput("hs_nextQuotient",  quotient, 32'd3);
        checkOutput("hs_nextRemainder", remainder, 32'd0);

        // Reset in the middle of an operation aborts it without a done pulse.
        @(negedge clock);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        repeat (14) begin
            @(negedge clock);
            start = 1'b0;
        end
        checkOutput("rst_busyBefore", W'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_busy",      W'(busy), '0);
        checkOutput("rst_quotient",  quotient, '0);
        checkOutput("rst_remainder", remainder, '0);
        checkOutput("rst_done",      W'(done), '0);
        repeat (2) @(negedge clock);
        reset   = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) sawDone = 1'b1;
        end
        checkOutput("rst_noDone", W'(sawDone), '0);
        applyStimulus(32'd9, 32'd3, lat, busyCnt);
        checkOutput("rst_nextLatency",   W'(lat),  32'd34);
        checkOutput("rst_nextQuotient",  quotient, 32'd3);
        checkOutput("rst_nextRemainder", remainder, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_restore_32.md
Name: div_restore_32

Overview:
- Iterative restoring divider for the processor's DIV instruction; subtraction-based counterpart of the datapath adder.
- Produces one quotient bit per cycle.
- Quotient goes to LO and remainder to HI through the ALU result mux.
- Accepts one operation per start pulse; completion is signalled by a single-cycle done pulse.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse; captures operands when the block is not busy.
- dividend  input  WIDTH  numerator, sampled only on an accepted start.
- divisor  input  WIDTH  denominator, sampled only on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done is asserted.
- done  output  1  one-cycle pulse; quotient and remainder are valid in this cycle.
- quotient  output  WIDTH  result, to LO; holds its value until the next accepted start.
- remainder  output  WIDTH  result, to HI; holds its value until the next accepted start.
- div_by_zero  output  1  valid with done; high when the captured divisor was 0.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter=0.
- States:
  - IDLE: start=1 loads R=0 (WIDTH+1 bits), Q=dividend and D=divisor, sets count=WIDTH, and moves to RUN. If divisor==0, it instead moves directly to FIN with the div_by_zero flag latched.
  - RUN: each cycle, shift {R,Q} left by 1 and compute T = R - {0,D} with a WIDTH+1-bit subtract.
    - T sign bit 0: R=T, Q[0]=1.
    - T sign bit 1: R is left unchanged (restore), Q[0]=0.
    - Decrement count; at count==1 the current cycle is the last iteration and the next state is FIN.
  - FIN: quotient=Q, remainder=R[WIDTH-1:0], done=1 for exactly this cycle, busy=0; next state is IDLE.
- Latency: start accepted at edge N gives done high during the cycle after edge N+WIDTH+1 (34 edges for WIDTH=32). A zero divisor gives done after edge N+1.
- Divide by zero: quotient=all ones, remainder=dividend, div_by_zero=1. These values are defined so that software sees deterministic results.
- start while busy (RUN or FIN) is ignored. Operands are not re-sampled and no queuing occurs.
- start during the FIN cycle is ignored; it is accepted on the following IDLE cycle.
- done and start in the same cycle are permitted; the start is ignored (see previous rule).
- Operand changes while busy have no effect.
- Reset asserted mid-operation aborts immediately. No done pulse is produced, and all outputs return to their reset values.
- Arithmetic is unsigned unless SIGNED_DIV_EN is defined. No overflow case exists for unsigned division.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SIGNED_DIV_EN
- Defined (two's-complement division):
  - On start, operand magnitudes are captured along with the sign of the quotient (dividend XOR divisor) and the sign of the remainder (dividend sign).
  - In FIN, quotient and remainder are negated when their respective sign is set, so the quotient truncates toward zero and the remainder takes the dividend's sign.
  - Most-negative / -1 returns quotient=most negative value and remainder=0, with no flag.
  - Divide by zero: quotient=all ones, remainder=dividend.
  - Latency is unchanged: negation happens inside the FIN cycle.
- Not defined: operands are treated as unsigned and no sign logic is synthesised.

Test Plan:
- Basic: dividend=100, divisor=7, start one cycle -> done exactly 34 cycles after the start edge; quotient=14, remainder=2; div_by_zero=0; busy high for 33 cycles.
- Extremes: dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=0xFFFFFFFF -> quotient=0, remainder=5.
- Divide by zero: dividend=0x1234, divisor=0 -> done 2 cycles after the start edge; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Handshake: dividend=50, divisor=5, then pulse start again with dividend=9, divisor=3 at cycle 10 and at the FIN cycle -> both pulses ignored; quotient=10, remainder=0. A new start the cycle after done is accepted.
- Reset mid-operation: start 1000/3, assert reset at cycle 15 for 2 cycles -> outputs drop to 0 asynchronously and no done pulse appears. A new start of 9/3 gives quotient=3, remainder=0.
- SIGNED_DIV_EN:
  - -7/2 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF).
  - 7/-2 -> quotient=-3, remainder=1.
  - 0x80000000/-1 -> quotient=0x80000000, remainder=0.
